his_peak_detect: RTL and testbench

Downstream stage of the dToF histogram builder. When all per-pixel histograms are complete, it scans each histogram's bins from histogram RAM and finds the peak (maximum-count) bin. It reports one peak result per pixel over a valid/ready handshake; the results feed the algebraic distance calculation stage.

---
 rtl/his_peak_detect_pkg.sv | 15 +
 rtl/his_peak_detect_peak_cmp.sv | 38 +++
 rtl/his_peak_detect.sv | 150 +++++++++++++++
 tb/tb_his_peak_detect.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/his_peak_detect_pkg.sv
// Shared constants and FSM encoding for the histogram stages.
package his_peak_detect_pkg;

  localparam int Nb                = 8;
  localparam int peakMax           = 8;
  localparam int PIXEL_NUM_PER_RAM = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/his_peak_detect_peak_cmp.sv
// Running-maximum tracker: keeps the largest count seen and the bin it came from.
module peak_cmp
  import his_peak_detect_pkg::*;
#(
  parameter int NB    = Nb,
  parameter int CNT_W = peakMax
) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [CNT_W-1:0] i_data,
  input  logic [NB-1:0]    i_bin,
  output logic [CNT_W-1:0] o_max,
  output logic [NB-1:0]    o_bin
);

  logic [CNT_W-1:0] r_max;
  logic [NB-1:0]    r_bin;

  // Strictly-greater update so that ties keep the earliest (lowest) bin.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_max <= '0;
      r_bin <= '0;
    end else if (i_clear) begin
      r_max <= '0;
      r_bin <= '0;
    end else if (i_valid && (i_data > r_max)) begin
      r_max <= i_data;
      r_bin <= i_bin;
    end
  end

  assign o_max = r_max;
  assign o_bin = r_bin;

endmodule

// File: rtl/his_peak_detect.sv
// Scans every per-pixel histogram in RAM and reports its peak bin over valid/ready.
// Optional HIS_CLEAR_EN: zero-writes each bin one cycle after it is read.
module his_peak_detect
  import his_peak_detect_pkg::*;
#(
  parameter int NB      = Nb,
  parameter int CNT_W   = peakMax,
  parameter int PIX_NUM = PIXEL_NUM_PER_RAM,
  parameter int PIX_W   = 2
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [PIX_W+NB-1:0]   rd_addr,
  input  logic [CNT_W-1:0]      rd_data,
  output logic                  peak_valid,
  input  logic                  peak_ready,
  output logic [PIX_W-1:0]      peak_pixel,
  output logic [NB-1:0]         peak_bin,
  output logic [CNT_W-1:0]      peak_count,
  output logic                  done
`ifdef HIS_CLEAR_EN
  ,
  output logic                  wr_en,
  output logic [PIX_W+NB-1:0]   wr_addr,
  output logic [CNT_W-1:0]      wr_data
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NB-1:0]    r_bin;
  logic [PIX_W-1:0] r_pix;
  logic             r_vld_p1;
  logic [NB-1:0]    r_bin_p1;
  logic             r_done;

  logic w_last_bin;
  logic w_last_pix;
  logic w_hs;
  logic w_clear;
  logic w_rd_en;
  logic w_peak_valid;
  logic w_busy;

  assign w_last_bin = (r_bin == {NB{1'b1}});
  assign w_last_pix = (r_pix == PIX_W'(PIX_NUM - 1));
  assign w_hs       = (r_state == OUT) && peak_ready;
  // Running max restarts whenever a new pixel scan is entered.
  assign w_clear    = ((r_state == IDLE) && start) || (w_hs && !w_last_pix);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_en      = 1'b0;
    w_peak_valid = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = SCAN;
      end
      SCAN: begin
        w_rd_en = 1'b1;
        if (w_last_bin) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_state_nxt = OUT;
      end
      OUT: begin
        w_peak_valid = 1'b1;
        if (peak_ready) w_state_nxt = w_last_pix ? IDLE : SCAN;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Bin counter wraps to 0 on the last read, ready for the next pixel.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_bin    <= '0;
      r_pix    <= '0;
      r_vld_p1 <= 1'b0;
      r_bin_p1 <= '0;
      r_done   <= 1'b0;
    end else begin
      if (r_state == SCAN) r_bin <= r_bin + NB'(1);
      if ((r_state == IDLE) && start) begin
        r_pix <= '0;
      end else if (w_hs) begin
        r_pix <= w_last_pix ? '0 : r_pix + PIX_W'(1);
      end
      r_vld_p1 <= w_rd_en;
      r_bin_p1 <= r_bin;
      r_done   <= w_hs && w_last_pix;
    end
  end

  peak_cmp #(
    .NB    (NB),
    .CNT_W (CNT_W)
  ) u_peak_cmp (
    .clk     (clk),
    .res     (res),
    .i_clear (w_clear),
    .i_valid (r_vld_p1),
    .i_data  (rd_data),
    .i_bin   (r_bin_p1),
    .o_max   (peak_count),
    .o_bin   (peak_bin)
  );

  assign busy       = w_busy;
  assign rd_en      = w_rd_en;
  assign rd_addr    = {r_pix, r_bin};
  assign peak_valid = w_peak_valid;
  assign peak_pixel = r_pix;
  assign done       = r_done;

`ifdef HIS_CLEAR_EN
  logic                r_wr_en;
  logic [PIX_W+NB-1:0] r_wr_addr;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en   <= w_rd_en;
      r_wr_addr <= {r_pix, r_bin};
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = '0;
`endif

endmodule

// File: tb/tb_his_peak_detect.sv
// Randomized scoreboard bench for his_peak_detect (NB=3, three pixels per RAM).
module tb_his_peak_detect;

  localparam int NB      = 3;
  localparam int CNT_W   = 8;
  localparam int PIX_NUM = 3;
  localparam int PIX_W   = 2;
  localparam int AW      = PIX_W + NB;
  localparam int NBINS   = 1 << NB;

  logic                clk = 1'b0;
  logic                res = 1'b0;
  logic                start = 1'b0;
  logic                peak_ready = 1'b0;
  logic                busy, rd_en, peak_valid, done;
  logic [AW-1:0]       rd_addr;
  logic [CNT_W-1:0]    rd_data = '0;
  logic [PIX_W-1:0]    peak_pixel;
  logic [NB-1:0]       peak_bin;
  logic [CNT_W-1:0]    peak_count;
`ifdef HIS_CLEAR_EN
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [CNT_W-1:0]    wr_data;
`endif

  his_peak_detect #(
    .NB(NB), .CNT_W(CNT_W), .PIX_NUM(PIX_NUM), .PIX_W(PIX_W)
  ) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .busy       (busy),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_pixel (peak_pixel),
    .peak_bin   (peak_bin),
    .peak_count (peak_count),
    .done       (done)
`ifdef HIS_CLEAR_EN
    ,
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [NB-1:0]    bin;
    logic [CNT_W-1:0] cnt;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  int   hist[PIX_NUM][NBINS];
  logic [CNT_W-1:0] img[0:(1<<AW)-1];
  logic [CNT_W-1:0] mem[0:(1<<AW)-1];
  logic load_req = 1'b0;

  // RAM model: bulk load from the bench image, 1-cycle read latency.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= img[i];
    end
`ifdef HIS_CLEAR_EN
    else if (wr_en) mem[wr_addr] <= wr_data;
`endif
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < (1 << AW); i++) img[i] = '0;
    for (int p = 0; p < PIX_NUM; p++)
      for (int b = 0; b < NBINS; b++) img[p*NBINS + b] = CNT_W'(hist[p][b]);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Reference: peak = maximum value, reported at the first bin holding it.
  task automatic push_expected();
    for (int p = 0; p < PIX_NUM; p++) begin
      int maxv = 0;
      int bi = 0;
      bit found = 0;
      for (int b = 0; b < NBINS; b++) if (hist[p][b] > maxv) maxv = hist[p][b];
      for (int b = 0; b < NBINS; b++)
        if (!found && hist[p][b] == maxv) begin bi = b; found = 1; end
      exp_q.push_back('{pix: PIX_W'(p), bin: NB'(bi), cnt: CNT_W'(maxv)});
    end
`ifdef HIS_CLEAR_EN
    for (int p = 0; p < PIX_NUM; p++)
      for (int b = 0; b < NBINS; b++) hist[p][b] = 0;
`endif
  endtask

  task automatic run(input int mode, input bit check_lat);
    int n;
    rdy_mode = mode;
    push_expected();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("scan_first_rd_en", rd_en, 1);
    chk("scan_first_addr", rd_addr, 0);
    chk("busy_after_start", busy, 1);
    if (check_lat) begin
      n = 1;
      while (!peak_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("first_valid_cycle", n, NBINS + 2);
    end
    n = 0;
    while (busy && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: busy still high after %0d cycles", n);
    end
  endtask

  // Ready driver: held high, 5-cycle stall per result, or random.
  initial begin
    int vcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!peak_valid) vcnt = 0; else vcnt++;
      case (rdy_mode)
        0:       peak_ready = 1'b1;
        1:       peak_ready = (vcnt > 5);
        default: peak_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability and done.
  initial begin
    bit   prev_stall = 0;
    bit   done_due = 0;
    res_t held = '0;
    res_t e;
    forever begin
      @(negedge clk);
      if (!res) begin
        prev_stall = 0;
        done_due = 0;
        continue;
      end
      if (done_due || done) begin
        chk("done_pulse", done, done_due);
        if (done_due) chk("busy_at_done", busy, 0);
      end
      done_due = 0;
      if (prev_stall) begin
        chk("stall_valid", peak_valid, 1);
        chk("stall_pixel", peak_pixel, held.pix);
        chk("stall_bin", peak_bin, held.bin);
        chk("stall_count", peak_count, held.cnt);
      end
      if (peak_valid && peak_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("peak_pixel", peak_pixel, e.pix);
          chk("peak_bin", peak_bin, e.bin);
          chk("peak_count", peak_count, e.cnt);
          if (e.pix == PIX_W'(PIX_NUM - 1)) done_due = 1;
        end
      end
      prev_stall = peak_valid && !peak_ready;
      held = '{pix: peak_pixel, bin: peak_bin, cnt: peak_count};
    end
  end

`ifdef HIS_CLEAR_EN
  initial begin
    bit            prev_rd = 0;
    logic [AW-1:0] prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!res) begin
        prev_rd = 0;
        continue;
      end
      if (prev_rd) begin
        chk("clear_wr_en", wr_en, 1);
        chk("clear_wr_addr", wr_addr, prev_addr);
        chk("clear_wr_data", wr_data, 0);
      end else if (wr_en) begin
        chk("spurious_wr_en", wr_en, 0);
      end
      prev_rd = rd_en;
      prev_addr = rd_addr;
    end
  end
`endif

  initial begin
    int d0[NBINS] = '{1, 4, 2, 9, 3, 0, 0, 5};
    int pk_bin[PIX_NUM] = '{6, 2, 7};
    int pk_val[PIX_NUM] = '{200, 150, 99};

    res = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_peak_valid", peak_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_addr", rd_addr, 0);
    res = 1'b1;
    @(posedge clk); #1;

    // Directed: example histogram, tie, all-zero; ready held high.
    for (int b = 0; b < NBINS; b++) begin
      hist[0][b] = d0[b];
      hist[1][b] = (b == 1 || b == 3) ? 7 : 0;
      hist[2][b] = 0;
    end
    load_all();
    run(0, 1);

    // Distinct peaks per pixel with a 5-cycle stall on every result.
    for (int p = 0; p < PIX_NUM; p++)
      for (int b = 0; b < NBINS; b++)
        hist[p][b] = (b == pk_bin[p]) ? pk_val[p] : $urandom_range(0, 90);
    load_all();
    run(1, 0);

    // Rescan without reloading: contents either persist or were cleared.
    run(2, 0);

    // Asynchronous reset in the middle of a scan.
    for (int p = 0; p < PIX_NUM; p++)
      for (int b = 0; b < NBINS; b++) hist[p][b] = $urandom_range(0, 255);
    load_all();
    rdy_mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    res = 1'b0;
    #1;
    chk("midreset_rd_en", rd_en, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_peak_valid", peak_valid, 0);
    chk("midreset_rd_addr", rd_addr, 0);
    exp_q.delete();
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    load_all();
    run(0, 1);

    // Randomized histograms, with small ranges to provoke ties.
    for (int it = 0; it < 20; it++) begin
      int hi = ($urandom_range(0, 2) == 0) ? 3 : 255;
      for (int p = 0; p < PIX_NUM; p++)
        for (int b = 0; b < NBINS; b++) hist[p][b] = $urandom_range(0, hi);
      load_all();
      run($urandom_range(0, 2), 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
